// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM port-B read burst controller.
package ram_rd_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_LOOP   = 1'b1;

endpackage

// File: rtl/ram_rd_lat_pipe.sv
// Valid shift register matching the RAM read latency; cleared synchronously.
module ram_rd_lat_pipe #(
   parameter int LAT = 1
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_in,
   output logic o_out
);

   logic [LAT-1:0] r_sh;

   // Shift the incoming strobe one stage per clock; clear drops everything in flight.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_sh <= {LAT{1'b0}};
      end else begin
         r_sh <= LAT'({r_sh, i_in});
      end
   end

   assign o_out = r_sh[LAT-1];

endmodule

// File: rtl/ram_rd_burst_ctrl.sv
// Read-side burst controller for simple dual-port RAM port B: issues one read per
// cycle with wrap at DEPTH, single or looping bursts, data/valid aligned to RD_LAT.
module ram_rd_burst_ctrl
   import ram_rd_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_burst_len,
   input  logic              i_loop_mode,
   input  logic              i_stop,
   output logic              o_ram_rd_en,
   output logic [ADDR_W-1:0] o_ram_rd_addr,
   input  logic [DATA_W-1:0] i_ram_rd_data,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   // Out-of-range base addresses start the burst at word 0.
   function automatic logic [ADDR_W-1:0] clamp_base(input logic [ADDR_W-1:0] a);
      if (int'(a) >= DEPTH) begin
         return ADDR_ZERO;
      end else begin
         return a;
      end
   endfunction

   // Next address, wrapping at DEPTH rather than at the power-of-two boundary.
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(DEPTH - 1)) begin
         return ADDR_ZERO;
      end else begin
         return a + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t            r_state;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_cnt;
   logic              r_loop;
   logic              r_busy;
   logic              r_done;
   logic              r_zero_len;

   logic              w_last;
   logic              w_to_flush;
   logic              w_valid;
   logic              w_flush_done;

   // Decide whether the read issued this cycle is the final one of the command.
   always_comb begin
      w_last     = 1'b0;
      w_to_flush = 1'b0;
      if (r_state == S_READ) begin
         w_last     = ((r_cnt + CNT_ONE) == r_len);
         w_to_flush = i_stop || (w_last && (r_loop == MODE_SINGLE));
      end else begin
         w_last     = 1'b0;
         w_to_flush = 1'b0;
      end
   end

   // rd_valid is the read enable delayed by the RAM latency.
   ram_rd_lat_pipe #(.LAT(RD_LAT)) u_valid_pipe (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_in  (r_rd_en),
      .o_out (w_valid)
   );

   // Marks the cycle the last in-flight word comes back, ending the flush.
   ram_rd_lat_pipe #(.LAT(RD_LAT)) u_flush_pipe (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_in  (w_to_flush),
      .o_out (w_flush_done)
   );

   // Control FSM with address/word counters and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_rd_en    <= 1'b0;
         r_rd_addr  <= ADDR_ZERO;
         r_base     <= ADDR_ZERO;
         r_len      <= CNT_ZERO;
         r_cnt      <= CNT_ZERO;
         r_loop     <= MODE_SINGLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_zero_len <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_base  <= clamp_base(i_base_addr);
                  r_len   <= i_burst_len;
                  r_loop  <= i_loop_mode;
                  r_cnt   <= CNT_ZERO;
                  r_busy  <= 1'b1;
                  if (i_burst_len == CNT_ZERO) begin
                     r_state    <= S_FLUSH;
                     r_zero_len <= 1'b1;
                     r_rd_en    <= 1'b0;
                  end else begin
                     r_state    <= S_READ;
                     r_zero_len <= 1'b0;
                     r_rd_en    <= 1'b1;
                     r_rd_addr  <= clamp_base(i_base_addr);
                  end
               end
            end
            S_READ: begin
               if (w_to_flush) begin
                  r_state   <= S_FLUSH;
                  r_rd_en   <= 1'b0;
                  r_rd_addr <= ADDR_ZERO;
               end else if (w_last) begin
                  r_cnt     <= CNT_ZERO;
                  r_rd_addr <= r_base;
               end else begin
                  r_cnt     <= r_cnt + CNT_ONE;
                  r_rd_addr <= wrap_inc(r_rd_addr);
               end
            end
            S_FLUSH: begin
               if (r_zero_len || w_flush_done) begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_zero_len <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_rd_en <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Pass RAM data through only while it is valid, so idle data reads as zero.
   always_comb begin
      o_rd_data = {DATA_W{1'b0}};
      if (w_valid) begin
         o_rd_data = i_ram_rd_data;
      end else begin
         o_rd_data = {DATA_W{1'b0}};
      end
   end

   assign o_rd_valid    = w_valid;
   assign o_ram_rd_en   = r_rd_en;
   assign o_ram_rd_addr = r_rd_addr;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule

// File: tb/tb_ram_rd_burst_ctrl.sv
// Scoreboard bench: three controllers (DEPTH 64/RD_LAT 1, DEPTH 48/RD_LAT 1,
// DEPTH 64/RD_LAT 3) each reading a RAM model holding mem[i]=i.
module tb_ram_rd_burst_ctrl;

   logic             clk = 1'b0;
   logic [2:0]       rst;
   logic [2:0]       start;
   logic [2:0]       loop_mode;
   logic [2:0]       stop;
   logic [2:0][5:0]  base;
   logic [2:0][6:0]  len;
   logic [2:0]       en;
   logic [2:0][5:0]  addr;
   logic [2:0][7:0]  ram_data;
   logic [2:0][7:0]  rd_data;
   logic [2:0]       valid;
   logic [2:0]       busy;
   logic [2:0]       done;

   logic [7:0]       ram_pipe [3][4];

   typedef struct {
      int inst;
      int data;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   int e_wrap64[8] = '{60, 61, 62, 63, 0, 1, 2, 3};
   int e_loop[7]   = '{10, 11, 12, 10, 11, 12, 10};
   int e_wrap48[5] = '{45, 46, 47, 0, 1};
   int e_lat3[4]   = '{62, 63, 0, 1};

   always #5 clk = ~clk;

   ram_rd_burst_ctrl #(.ADDR_W(6), .DEPTH(64), .DATA_W(8), .RD_LAT(1)) u_dut0 (
      .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_base_addr(base[0]),
      .i_burst_len(len[0]), .i_loop_mode(loop_mode[0]), .i_stop(stop[0]),
      .o_ram_rd_en(en[0]), .o_ram_rd_addr(addr[0]), .i_ram_rd_data(ram_data[0]),
      .o_rd_data(rd_data[0]), .o_rd_valid(valid[0]), .o_busy(busy[0]), .o_done(done[0]));

   ram_rd_burst_ctrl #(.ADDR_W(6), .DEPTH(48), .DATA_W(8), .RD_LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_base_addr(base[1]),
      .i_burst_len(len[1]), .i_loop_mode(loop_mode[1]), .i_stop(stop[1]),
      .o_ram_rd_en(en[1]), .o_ram_rd_addr(addr[1]), .i_ram_rd_data(ram_data[1]),
      .o_rd_data(rd_data[1]), .o_rd_valid(valid[1]), .o_busy(busy[1]), .o_done(done[1]));

   ram_rd_burst_ctrl #(.ADDR_W(6), .DEPTH(64), .DATA_W(8), .RD_LAT(3)) u_dut2 (
      .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .i_base_addr(base[2]),
      .i_burst_len(len[2]), .i_loop_mode(loop_mode[2]), .i_stop(stop[2]),
      .o_ram_rd_en(en[2]), .o_ram_rd_addr(addr[2]), .i_ram_rd_data(ram_data[2]),
      .o_rd_data(rd_data[2]), .o_rd_valid(valid[2]), .o_busy(busy[2]), .o_done(done[2]));

   // RAM models: mem[i] = i, read latency set by the pipeline tap.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         ram_pipe[k][0] <= {2'b00, addr[k]};
         for (int j = 1; j < 4; j++) begin
            ram_pipe[k][j] <= ram_pipe[k][j-1];
         end
      end
   end

   assign ram_data[0] = ram_pipe[0][0];
   assign ram_data[1] = ram_pipe[1][0];
   assign ram_data[2] = ram_pipe[2][2];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input int v);
      exp_t e;
      e.inst = k;
      e.data = v;
      sb.push_back(e);
   endtask

   // Monitor: every rd_valid pops the next expected word and compares it.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (valid[k]) begin
            if (sb.size() == 0) begin
               chk($sformatf("unexpected_rd_valid_dut%0d", k), int'(valid[k]), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("rd_data_dut%0d", k), int'(rd_data[k]), e.data);
            end
         end
      end
   end

   // Issue one command and track done/busy/issue counts relative to the start edge.
   task automatic run_cmd(input int k, input int b, input int n, input bit lp,
                          input int stop_after, input int dup_at,
                          input int exp_done, input int exp_busy, input int exp_iss);
      int c;
      int busy_n;
      int iss;
      int done_at;
      @(posedge clk); #1;
      start[k]     = 1'b1;
      base[k]      = 6'(b);
      len[k]       = 7'(n);
      loop_mode[k] = lp;
      stop[k]      = lp;
      @(posedge clk); #1;
      c       = 1;
      busy_n  = 0;
      iss     = 0;
      done_at = 0;
      while (c < 300 && done_at == 0) begin
         start[k] = 1'b0;
         stop[k]  = 1'b0;
         if (busy[k]) busy_n++;
         if (en[k]) begin
            iss++;
            if (iss == stop_after) stop[k] = 1'b1;
         end
         if (c == dup_at) begin
            start[k] = 1'b1;
            base[k]  = 6'd30;
            len[k]   = 7'd2;
         end
         if (done[k]) begin
            done_at = c;
         end else begin
            @(posedge clk); #1;
            c++;
         end
      end
      chk($sformatf("done_cycle_dut%0d", k), done_at, exp_done);
      chk($sformatf("busy_cycles_dut%0d", k), busy_n, exp_busy);
      chk($sformatf("issues_dut%0d", k), iss, exp_iss);
      @(posedge clk); #1;
      chk($sformatf("done_one_cycle_dut%0d", k), int'(done[k]), 0);
      chk($sformatf("busy_after_dut%0d", k), int'(busy[k]), 0);
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d;
      rst       = 3'b111;
      start     = 3'b000;
      loop_mode = 3'b000;
      stop      = 3'b000;
      base      = '0;
      len       = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_rd_en", int'(en[0]), 0);
      chk("rst_ram_rd_addr", int'(addr[0]), 0);
      chk("rst_rd_valid", int'(valid[0]), 0);
      chk("rst_rd_data", int'(rd_data[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      rst = 3'b000;

      // Full-depth single burst.
      for (int i = 0; i < 64; i++) push(0, i);
      run_cmd(0, 0, 64, 1'b0, 0, 0, 66, 65, 64);

      // Wrap at 63 -> 0, with an ignored start while busy.
      foreach (e_wrap64[i]) push(0, e_wrap64[i]);
      run_cmd(0, 60, 8, 1'b0, 0, 3, 10, 9, 8);

      // Loop mode, stop dropped at start, then stop after seven issues.
      foreach (e_loop[i]) push(0, e_loop[i]);
      run_cmd(0, 10, 3, 1'b1, 7, 0, 9, 8, 7);

      // Zero-length command.
      run_cmd(0, 5, 0, 1'b0, 0, 0, 2, 1, 0);

      // Non-power-of-two depth wraps at 47.
      foreach (e_wrap48[i]) push(1, e_wrap48[i]);
      run_cmd(1, 45, 5, 1'b0, 0, 0, 7, 6, 5);

      // Base beyond DEPTH clamps to 0.
      push(1, 0);
      push(1, 1);
      run_cmd(1, 50, 2, 1'b0, 0, 0, 4, 3, 2);

      // Three-cycle latency burst with wrap.
      foreach (e_lat3[i]) push(2, e_lat3[i]);
      run_cmd(2, 62, 4, 1'b0, 0, 0, 8, 7, 4);

      // Reset mid-burst on the latency-3 controller: two words land before reset.
      push(2, 0);
      push(2, 1);
      @(posedge clk); #1;
      start[2] = 1'b1;
      base[2]  = 6'd0;
      len[2]   = 7'd20;
      loop_mode[2] = 1'b0;
      @(posedge clk); #1;
      start[2] = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst[2] = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ram_rd_en", int'(en[2]), 0);
      chk("midrst_ram_rd_addr", int'(addr[2]), 0);
      chk("midrst_rd_valid", int'(valid[2]), 0);
      chk("midrst_rd_data", int'(rd_data[2]), 0);
      chk("midrst_busy", int'(busy[2]), 0);
      chk("midrst_done", int'(done[2]), 0);
      rst[2] = 1'b0;
      d = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done[2]) d++;
      end
      chk("midrst_no_done", d, 0);
      chk("midrst_scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
